serial_adder: RTL and testbench

- Bit-serial multi-bit adder built around a single 1-bit add cell; one operand bit pair per clock, LSB first.
- Sits directly above the team's 1-bit half-adder cell and sequences it: two half adders plus OR form the full-add cell, and this block supplies the carry register, shift registers and control.
- Trades latency (WIDTH cycles) for area; operands are loaded by a start pulse, and the result is flagged with a done pulse.

---
 rtl/serial_adder_pkg.sv | 18 +
 rtl/full_add_cell.sv | 30 +++
 rtl/half_add_cell.sv | 12 +
 rtl/serial_adder.sv | 144 ++++++++++++++
 tb/tb_serial_adder.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
// Holds the FSM state encoding, the default width and the bit-counter width function.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned DefaultWidth = 8;

  // One extra bit so the counter can hold WIDTH itself without wrapping.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/full_add_cell.sv
// Combinational 1-bit full adder built from two half-adder cells and an OR for the carry.
module full_add_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  logic s1;
  logic c1;
  logic c2;

  half_add_cell u_ha0 (
    .a_i (a_i),
    .b_i (b_i),
    .s_o (s1),
    .c_o (c1)
  );

  half_add_cell u_ha1 (
    .a_i (s1),
    .b_i (ci_i),
    .s_o (s_o),
    .c_o (c2)
  );

  assign co_o = c1 | c2;

endmodule

// File: rtl/half_add_cell.sv
// 1-bit half adder: the basic add cell the serial adder is built from.
module half_add_cell (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one bit pair per clock, LSB first, through a single full-add cell.
// Optional two's-complement overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             cout_o,
  output logic             ovf_o
`else
  output logic             cout_o
`endif
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  state_e state_q, state_d;

  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             accept;
  logic             last_step;
  logic             fa_s;
  logic             fa_co;

  // Start is only honoured outside RUN; a start in DONE chains straight into the next RUN.
  assign accept    = start_i & ((state_q == StIdle) | (state_q == StDone));
  assign last_step = (cnt_q == CntW'(WIDTH - 1));

  full_add_cell u_fa (
    .a_i  (ra_q[0]),
    .b_i  (rb_q[0]),
    .ci_i (carry_q),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRun;
      StRun:   if (last_step) state_d = StDone;
      StDone:  state_d = accept ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_o = (state_q == StRun);
    done_o = (state_q == StDone);
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    ra_d    = ra_q;
    rb_d    = rb_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    if (accept) begin
      ra_d    = a_i;
      rb_d    = b_i;
      carry_d = cin_i;
      cnt_d   = '0;
      sum_d   = '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d   = 1'b0;
`endif
    end else if (state_q == StRun) begin
      ra_d    = {1'b0, ra_q[WIDTH-1:1]};
      rb_d    = {1'b0, rb_q[WIDTH-1:1]};
      sum_d   = {fa_s, sum_q[WIDTH-1:1]};
      carry_d = fa_co;
      cnt_d   = cnt_q + 1'b1;
      if (last_step) begin
        cout_d = fa_co;
`ifdef SERIAL_ADDER_OVF_EN
        // Carry into the MSB step differs from carry out of it.
        ovf_d  = carry_q ^ fa_co;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra_q    <= '0;
      rb_q    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign sum_o  = sum_q;
  assign cout_o = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf_o  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=8 and WIDTH=13; checks ovf when SERIAL_ADDER_OVF_EN is set.
module tb_serial_adder;

  localparam int W  = 8;
  localparam int W2 = 13;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start8 = 1'b0, cin8 = 1'b0, busy8, done8, cout8;
  logic [W-1:0]  a8 = '0, b8 = '0, sum8;
  logic          start13 = 1'b0, cin13 = 1'b0, busy13, done13, cout13;
  logic [W2-1:0] a13 = '0, b13 = '0, sum13;
`ifdef SERIAL_ADDER_OVF_EN
  logic          ovf8, ovf13;
`endif

  int   n_checks = 0;
  int   n_fail = 0;
  int   done_cnt8 = 0;
  exp_t q8[$];
  exp_t q13[$];

  serial_adder #(.WIDTH(W)) u_dut8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start8),
    .a_i     (a8),
    .b_i     (b8),
    .cin_i   (cin8),
    .busy_o  (busy8),
    .done_o  (done8),
    .sum_o   (sum8),
`ifdef SERIAL_ADDER_OVF_EN
    .cout_o  (cout8),
    .ovf_o   (ovf8)
`else
    .cout_o  (cout8)
`endif
  );

  serial_adder #(.WIDTH(W2)) u_dut13 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start13),
    .a_i     (a13),
    .b_i     (b13),
    .cin_i   (cin13),
    .busy_o  (busy13),
    .done_o  (done13),
    .sum_o   (sum13),
`ifdef SERIAL_ADDER_OVF_EN
    .cout_o  (cout13),
    .ovf_o   (ovf13)
`else
    .cout_o  (cout13)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic cin);
    logic [64:0] full;
    logic [64:0] mask;
    exp_t e;
    full   = {1'b0, a} + {1'b0, b} + {64'd0, cin};
    mask   = (65'd1 << w) - 65'd1;
    e.sum  = full[63:0] & mask[63:0];
    e.cout = full[w];
    e.ovf  = (a[w-1] == b[w-1]) && (e.sum[w-1] != a[w-1]);
    return e;
  endfunction

  // Monitors: pop the oldest expected result whenever a DUT flags done.
  always @(negedge clk) begin
    if (rst_n && done8) begin
      exp_t e;
      done_cnt8++;
      if (q8.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done8: got done with empty scoreboard, expected none");
      end else begin
        e = q8.pop_front();
        check("sum8", {56'd0, sum8}, e.sum);
        check("cout8", {63'd0, cout8}, {63'd0, e.cout});
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf8", {63'd0, ovf8}, {63'd0, e.ovf});
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done13) begin
      exp_t e;
      if (q13.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done13: got done with empty scoreboard, expected none");
      end else begin
        e = q13.pop_front();
        check("sum13", {51'd0, sum13}, e.sum);
        check("cout13", {63'd0, cout13}, {63'd0, e.cout});
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf13", {63'd0, ovf13}, {63'd0, e.ovf});
`endif
      end
    end
  end

  // Called #1 after an edge; leaves us #1 after the edge that sampled start.
  task automatic go8(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                     input exp_t e, input bit push);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    if (push) q8.push_back(e);
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  task automatic wait_done8(output int n);
    n = 0;
    while (!done8 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done8) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout_done8: got no done after %0d cycles, expected done", n);
    end
  endtask

  task automatic go13(input logic [W2-1:0] a, input logic [W2-1:0] b, input logic c);
    a13 = a; b13 = b; cin13 = c; start13 = 1'b1;
    q13.push_back(model(W2, {51'd0, a}, {51'd0, b}, c));
    @(posedge clk); #1;
    start13 = 1'b0;
  endtask

  task automatic wait_done13();
    int n = 0;
    while (!done13 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done13) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout_done13: got no done after %0d cycles, expected done", n);
    end
  endtask

  initial begin
    int n;
    int m;
    int d0;
    int gap;

    // Reset state
    #1;
    check("rst_busy", {63'd0, busy8}, 64'd0);
    check("rst_done", {63'd0, done8}, 64'd0);
    check("rst_sum", {56'd0, sum8}, 64'd0);
    check("rst_cout", {63'd0, cout8}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 0x5A + 0x3C: busy for W cycles, done one cycle later
    go8(8'h5A, 8'h3C, 1'b0, '{sum: 64'h96, cout: 1'b0, ovf: 1'b1}, 1'b1);
    for (int i = 0; i < W; i++) begin
      check("busy_run", {63'd0, busy8}, 64'd1);
      check("done_low_run", {63'd0, done8}, 64'd0);
      @(posedge clk); #1;
    end
    check("done_pulse", {63'd0, done8}, 64'd1);
    check("busy_in_done", {63'd0, busy8}, 64'd0);
    @(posedge clk); #1;
    check("done_one_cycle", {63'd0, done8}, 64'd0);
    check("sum_held", {56'd0, sum8}, 64'h96);

    // Carry out of MSB lands only in cout
    go8(8'hFF, 8'h01, 1'b0, '{sum: 64'h00, cout: 1'b1, ovf: 1'b0}, 1'b1);
    wait_done8(n);
    check("latency_ff01", n, W);
    @(posedge clk); #1;
    go8(8'hFF, 8'h00, 1'b1, '{sum: 64'h00, cout: 1'b1, ovf: 1'b0}, 1'b1);
    wait_done8(n);
    @(posedge clk); #1;

    // Start re-pulsed mid-RUN is ignored
    go8(8'h33, 8'h44, 1'b1, '{sum: 64'h78, cout: 1'b0, ovf: 1'b0}, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    wait_done8(m);
    check("latency_repulse", 3 + m, W);
    @(posedge clk); #1;

    // Back-to-back: start in the DONE cycle
    go8(8'h0F, 8'hF0, 1'b1, '{sum: 64'h00, cout: 1'b1, ovf: 1'b0}, 1'b1);
    wait_done8(n);
    go8(8'h01, 8'h01, 1'b0, '{sum: 64'h02, cout: 1'b0, ovf: 1'b0}, 1'b1);
    check("b2b_sum_cleared", {56'd0, sum8}, 64'd0);
    check("b2b_busy", {63'd0, busy8}, 64'd1);
    wait_done8(n);
    check("b2b_latency", n, W);
    @(posedge clk); #1;

    // Reset mid-RUN aborts with no done pulse
    go8(8'h5A, 8'h3C, 1'b0, '{sum: 64'h0, cout: 1'b0, ovf: 1'b0}, 1'b0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", {63'd0, busy8}, 64'd0);
    check("arst_done", {63'd0, done8}, 64'd0);
    check("arst_sum", {56'd0, sum8}, 64'd0);
    check("arst_cout", {63'd0, cout8}, 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("arst_ovf", {63'd0, ovf8}, 64'd0);
`endif
    d0 = done_cnt8;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (W + 3) begin
      @(posedge clk); #1;
    end
    check("no_done_after_rst", done_cnt8, d0);
    go8(8'h12, 8'h34, 1'b1, '{sum: 64'h47, cout: 1'b0, ovf: 1'b0}, 1'b1);
    wait_done8(n);
    check("post_rst_latency", n, W);
    @(posedge clk); #1;

    // Random sweep, gap 0 gives a start in the DONE cycle
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      go8(ra, rb, rc, model(W, {56'd0, ra}, {56'd0, rb}, rc), 1'b1);
      wait_done8(n);
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;

    for (int i = 0; i < 1000; i++) begin
      go13(W2'($urandom), W2'($urandom), 1'($urandom));
      wait_done13();
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    @(posedge clk); #1;

    check("q8_drained", q8.size(), 64'd0);
    check("q13_drained", q13.size(), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
